// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box draw/scan blocks.
package bbox_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned COORD_W         = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StTop,
    StBottom,
    StLeft,
    StRight,
    StFinished
  } state_e;

endpackage

// File: rtl/bbox_if.sv
// Start/done handshake, box/colour inputs and the byte-wide frame-memory write port.
interface bbox_if
  import bbox_pkg::*;
();

  logic        start;
  logic        done;
  coord_t      xMin;
  coord_t      xMax;
  coord_t      yMin;
  coord_t      yMax;
  logic [7:0]  colour_r;
  logic [7:0]  colour_g;
  logic [7:0]  colour_b;
  logic [31:0] wraddr;
  logic [15:0] wrdata;
  logic        wren;
  logic        wrready;

  modport master (
    output start, xMin, xMax, yMin, yMax, colour_r, colour_g, colour_b, wrready,
    input  done, wraddr, wrdata, wren
  );

  modport slave (
    input  start, xMin, xMax, yMin, yMax, colour_r, colour_g, colour_b, wrready,
    output done, wraddr, wrdata, wren
  );

endinterface

// File: rtl/bbox_addr_gen.sv
// Frame-memory layout: row-major pixels, three byte lanes (R, G, B) per pixel.
module bbox_addr_gen
  import bbox_pkg::*;
#(
  parameter int unsigned WIDTH = 100
) (
  input  coord_t      x,
  input  coord_t      y,
  input  logic [1:0]  rgb,
  output logic [31:0] addr
);

  localparam logic [31:0] ROW_BYTES = 32'(WIDTH * BYTES_PER_PIXEL);
  localparam logic [31:0] PIX_BYTES = 32'(BYTES_PER_PIXEL);

  assign addr = 32'(y) * ROW_BYTES + 32'(x) * PIX_BYTES + 32'(rgb);

endmodule

// File: rtl/bbox_draw.sv
// Draws a 1-pixel rectangle outline into frame memory, one byte write per cycle,
// stalling on wrready. Order: top row, bottom row, left column, right column.
module bbox_draw
  import bbox_pkg::*;
#(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100
) (
  input  logic  clk,
  input  logic  rst_n,
  bbox_if.slave bus
);

  localparam coord_t X_LAST = coord_t'(WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);

  state_e      state_q, state_d;
  coord_t      x_q, y_q, x_d, y_d;
  logic [1:0]  rgb_q, rgb_d;
  coord_t      x_min_q, x_max_q, y_min_q, y_max_q;
  logic [7:0]  col_r_q, col_g_q, col_b_q;
  logic        wren_q, done_q;
  logic [31:0] wraddr_q, addr_d;
  logic [15:0] wrdata_q;

  coord_t      in_x_min, in_x_max, in_y_min, in_y_max;
  logic        in_invalid, go, adv, tall;
  logic [7:0]  src_r, src_g, src_b, col_d;

  function automatic coord_t clamp(input coord_t v, input coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

  assign in_x_min   = clamp(bus.xMin, X_LAST);
  assign in_x_max   = clamp(bus.xMax, X_LAST);
  assign in_y_min   = clamp(bus.yMin, Y_LAST);
  assign in_y_max   = clamp(bus.yMax, Y_LAST);
  assign in_invalid = (in_x_min > in_x_max) || (in_y_min > in_y_max);

  assign go   = bus.start && (state_q == StIdle || state_q == StFinished);
  assign adv  = wren_q && bus.wrready;
  // Latched box is always valid here, so the subtraction cannot wrap.
  assign tall = (y_max_q - y_min_q) >= coord_t'(2);

  // Position of the write that follows the one currently on the bus.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q + 2'd1;
    if (go) begin
      state_d = in_invalid ? StFinished : StTop;
      x_d     = in_x_min;
      y_d     = in_y_min;
      rgb_d   = 2'd0;
    end else if (rgb_q == 2'd2) begin
      rgb_d = 2'd0;
      case (state_q)
        StTop: begin
          if (x_q != x_max_q) begin
            x_d = x_q + coord_t'(1);
          end else if (y_max_q != y_min_q) begin
            state_d = StBottom;
            x_d     = x_min_q;
            y_d     = y_max_q;
          end else begin
            state_d = StFinished;
          end
        end
        StBottom: begin
          if (x_q != x_max_q) begin
            x_d = x_q + coord_t'(1);
          end else if (tall) begin
            state_d = StLeft;
            x_d     = x_min_q;
            y_d     = y_min_q + coord_t'(1);
          end else begin
            state_d = StFinished;
          end
        end
        StLeft: begin
          if (y_q != y_max_q - coord_t'(1)) begin
            y_d = y_q + coord_t'(1);
          end else if (x_max_q != x_min_q) begin
            state_d = StRight;
            x_d     = x_max_q;
            y_d     = y_min_q + coord_t'(1);
          end else begin
            state_d = StFinished;
          end
        end
        StRight: begin
          if (y_q != y_max_q - coord_t'(1)) begin
            y_d = y_q + coord_t'(1);
          end else begin
            state_d = StFinished;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    src_r = go ? bus.colour_r : col_r_q;
    src_g = go ? bus.colour_g : col_g_q;
    src_b = go ? bus.colour_b : col_b_q;
    case (rgb_d)
      2'd0:    col_d = src_r;
      2'd1:    col_d = src_g;
      default: col_d = src_b;
    endcase
  end

  bbox_addr_gen #(
    .WIDTH(WIDTH)
  ) u_addr_gen (
    .x   (x_d),
    .y   (y_d),
    .rgb (rgb_d),
    .addr(addr_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      x_min_q  <= '0;
      x_max_q  <= '0;
      y_min_q  <= '0;
      y_max_q  <= '0;
      col_r_q  <= '0;
      col_g_q  <= '0;
      col_b_q  <= '0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      if (go) begin
        x_min_q <= in_x_min;
        x_max_q <= in_x_max;
        y_min_q <= in_y_min;
        y_max_q <= in_y_max;
        col_r_q <= bus.colour_r;
        col_g_q <= bus.colour_g;
        col_b_q <= bus.colour_b;
      end
      if (go || adv) begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        rgb_q   <= rgb_d;
        wren_q  <= (state_d != StFinished);
        done_q  <= (state_d == StFinished);
        if (state_d != StFinished) begin
          wraddr_q <= addr_d;
          wrdata_q <= {8'h00, col_d};
        end
      end
    end
  end

  assign bus.wren   = wren_q;
  assign bus.wraddr = wraddr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.done   = done_q;

endmodule
